clock_phase_sequencer: RTL
==========================

Name: clock_phase_sequencer

Overview:
- Controls how the processor datapath uses the free-running system clock.
- Produces a one-cycle clock-enable strobe (Tick) at a programmable rate.
- Steps a one-hot phase vector through IF/DEC/EXE/MEM/WB.
- Supports free-run, single-instruction step, and datapath stall (Hold). Sits between the clock source and every multicycle datapath stage.

Parameters:
DIV_WIDTH, 8, width of the Div divide-ratio input and the internal down-counter
NUM_PHASES, 5, number of phases per instruction (one-hot width of Phase)
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
Clk  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-low reset
Run  input  1  level; 1 = free-run instructions
Step_req  input  1  request to execute exactly one instruction; sampled in IDLE only
Hold  input  1  datapath stall; suppresses Tick while 1
Div  input  DIV_WIDTH  Tick period minus 1, in Clk cycles; sampled only at counter reload
Tick  output  1  clock-enable strobe for the datapath stages
Phase  output  NUM_PHASES  one-hot current phase; bit 0 = IF, bit NUM_PHASES-1 = WB
Instr_done  output  1  high in the Tick cycle of the last phase
Step_ack  output  1  one-cycle pulse when a stepped instruction completes
Busy  output  1  state != IDLE
Instr_count  output  CNT_WIDTH  number of retired instructions

Behaviour:
- Reset (Reset=0 at a rising edge): state=IDLE, Phase=1 (IF), counter=0, Instr_count=0, Step_ack=0.
  - Tick, Instr_done and Busy are 0 while in IDLE.
  - Reset mid-instruction abandons the instruction; no Instr_done and no Step_ack are produced.
- States: IDLE, RUN, STEP. Registered state, one-hot Phase register, DIV_WIDTH down-counter.
- IDLE:
  - Run=1 -> RUN.
  - Otherwise Step_req=1 -> STEP.
  - If both are 1, Run wins and Step_req is dropped, not queued.
  - On entry to RUN or STEP, counter<=Div.
- Tick is combinational from registered state: Tick = (state!=IDLE) && counter==0 && !Hold.
- Counter in RUN/STEP, per cycle:
  - counter!=0: decrement. Hold does not stop the decrement.
  - counter==0 and Hold=1: hold at 0, no Tick.
  - counter==0 and Hold=0: Tick=1, counter<=Div (Div sampled here), Phase rotates left one bit; WB wraps to IF.
- Tick rate: with Div=N and Hold=0, the first Tick comes N cycles after entering RUN, then one Tick every N+1 cycles. Div=0 gives Tick every cycle.
- Instr_done = Tick && Phase[NUM_PHASES-1].
  - At the same edge, Instr_count<=Instr_count+1, wrapping from 2^CNT_WIDTH-1 to 0.
- RUN:
  - Run deasserting does not stop the block mid-instruction. It continues until Instr_done, then goes to IDLE with Phase=IF.
  - If Run=1 at the Instr_done edge, the block stays in RUN.
  - Step_req is ignored.
- STEP:
  - Executes exactly NUM_PHASES Ticks. Run and Step_req are ignored.
  - At Instr_done -> IDLE, and Step_ack=1 for the following cycle only.
  - Step_req held high then re-triggers STEP from IDLE on the next cycle. Holding Step_req high runs one instruction per grant, each with its own Step_ack.
- Phase is always exactly one-hot. Phase changes only on Tick or reset.
- Div change mid-count has no effect until the next reload.
- Hold asserted in IDLE has no effect.

Test Plan:
- Reset=0 for 2 cycles, then 1 with Run=0 -> Phase=5'b00001, Tick=0, Busy=0, Instr_count=0, Step_ack=0.
- Div=0, Run=1 for 12 cycles then 0 -> Tick every cycle; Phase 1,2,4,8,16,1,...; Instr_done at Ticks 5 and 10.
  - Block completes the third instruction (Tick 15), then IDLE with Phase=1 and Instr_count=3.
- Div=3, Run=1 -> first Tick 3 cycles after RUN entry, then every 4 cycles; Instr_done once per 20 cycles.
  - Div changed to 1 mid-count -> new period of 2 takes effect only after the next Tick.
- Step_req 1-cycle pulse, Div=0 -> exactly 5 Ticks, Step_ack high 1 cycle after Instr_done, Busy back to 0, Instr_count +1.
  - Step_req asserted during RUN -> ignored, no Step_ack.
- Div=0, RUN, Hold=1 for 4 cycles while Phase=EXE -> Tick=0 and Phase stays 4 for 4 cycles; Tick resumes on the first cycle Hold=0.
- Instr_count preloaded near wrap (force to 2^32-1), one instruction -> Instr_count=0.
  - Reset=0 asserted during MEM in STEP -> IDLE, Phase=1, no Step_ack.

Source files
------------

// File: rtl/clock_phase_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_phase_sequencer_if                                             |
// | Control inputs and phase/strobe outputs of the clock phase sequencer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface clock_phase_sequencer_if #(
    parameter int DIV_WIDTH  = 8,
    parameter int NUM_PHASES = 5,
    parameter int CNT_WIDTH  = 32
) ();
    logic                  run;
    logic                  step_req;
    logic                  hold;
    logic [DIV_WIDTH-1:0]  div;
    logic                  tick;
    logic [NUM_PHASES-1:0] phase;
    logic                  instr_done;
    logic                  step_ack;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  instr_count;

    modport master (
        output run, step_req, hold, div,
        input  tick, phase, instr_done, step_ack, busy, instr_count
    );

    modport slave (
        input  run, step_req, hold, div,
        output tick, phase, instr_done, step_ack, busy, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/clock_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_phase_sequencer                                                |
// | Programmable-rate tick strobe and one-hot instruction phase stepper  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module clock_phase_sequencer #(
    parameter int DIV_WIDTH  = 8,
    parameter int NUM_PHASES = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    clock_phase_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [NUM_PHASES-1:0] PHASE_IF = {{(NUM_PHASES-1){1'b0}}, 1'b1};

    state_t                state;
    logic [DIV_WIDTH-1:0]  counter;
    logic [NUM_PHASES-1:0] phase_q;
    logic                  tick_w;
    logic                  done_w;

    // Tick depends on Hold combinationally so a stall takes effect in the same cycle.
    assign tick_w         = (state != S_IDLE) && (counter == '0) && !bus.hold;
    assign done_w         = tick_w && phase_q[NUM_PHASES-1];
    assign bus.tick       = tick_w;
    assign bus.instr_done = done_w;
    assign bus.busy       = (state != S_IDLE);
    assign bus.phase      = phase_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            counter         <= '0;
            phase_q         <= PHASE_IF;
            bus.instr_count <= '0;
            bus.step_ack    <= 1'b0;
        end else begin
            bus.step_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        state   <= S_RUN;
                        counter <= bus.div;
                    end else if (bus.step_req) begin
                        state   <= S_STEP;
                        counter <= bus.div;
                    end
                end
                S_RUN, S_STEP: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else if (!bus.hold) begin
                        counter <= bus.div;
                        phase_q <= {phase_q[NUM_PHASES-2:0], phase_q[NUM_PHASES-1]};
                        if (phase_q[NUM_PHASES-1]) begin
                            bus.instr_count <= bus.instr_count + 1'b1;
                            // A stepped instruction always ends; a free run ends only once Run drops.
                            if (state == S_STEP) begin
                                state        <= S_IDLE;
                                bus.step_ack <= 1'b1;
                            end else if (!bus.run) begin
                                state <= S_IDLE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
